// File: rtl/i2c_reg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_reg_target
// Purpose  : I2C target engine bridging an I2C controller to a local register
//            bus. Frame: 7-bit device address, register address high byte,
//            register address low byte, then write data or a repeated START
//            followed by read data. Each data byte becomes a one-clk strobe.
//            SCL is observed only; the clock is never stretched.
// Ports    : clk        - system clock (>= 20x SCL frequency)
//            rst_n      - asynchronous active-low reset
//            i2c_sclk   - I2C clock input
//            i2c_sdat   - I2C data, open-drain (drives 0 or z only)
//            reg_addr   - register pointer for the current access
//            reg_wdata  - write data, valid while reg_wr is high
//            reg_wr     - one-clk write strobe
//            reg_rd     - one-clk read strobe
//            reg_rdata  - read data, presented the clk after reg_rd
//            busy       - high from address match until STOP or next START
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEV       = 4'd1,
    S_DEV_ACK   = 4'd2,
    S_RAH       = 4'd3,
    S_RAH_ACK   = 4'd4,
    S_RAL       = 4'd5,
    S_RAL_ACK   = 4'd6,
    S_WDATA     = 4'd7,
    S_WDATA_ACK = 4'd8,
    S_RDATA     = 4'd9,
    S_RDATA_ACK = 4'd10,
    S_WAIT_STOP = 4'd11
  } state_t;

  localparam logic [3:0] C_LAST_BIT  = 4'd7;
  localparam logic [3:0] C_BYTE_DONE = 4'd8;

  // --------------------------------------------------------------------------
  // Input synchronizers: two flops to resolve metastability, one history flop
  // so edges are seen as (synced, history) pairs.
  // --------------------------------------------------------------------------
  logic r_scl_meta, r_scl_sync, r_scl_hist;
  logic r_sda_meta, r_sda_sync, r_sda_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_meta <= i2c_sclk;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= i2c_sdat;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_sync & ~r_scl_hist;
  assign w_scl_fall = ~r_scl_sync & r_scl_hist;
  // Both synchronizers have equal depth, so SCL-high qualification of an SDA
  // edge reflects the true pin ordering.
  assign w_start    = r_scl_sync & ~r_sda_sync &  r_sda_hist;
  assign w_stop     = r_scl_sync &  r_sda_sync & ~r_sda_hist;

  // --------------------------------------------------------------------------
  // Datapath / FSM registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_rdata_cap;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_wr;
  logic        r_rd;
  logic        r_rd_d;
  logic        r_rw;
  logic        r_busy;
  logic        r_sda_oe;

  // Byte as it stands once the current (8th) bit is shifted in.
  logic [7:0] w_byte;
  assign w_byte = {r_shift[6:0], r_sda_sync};

  // ACK state that follows each byte-receiving state.
  state_t w_ack_state;
  always_comb begin
    w_ack_state = S_IDLE;
    case (r_state)
      S_DEV:   w_ack_state = S_DEV_ACK;
      S_RAH:   w_ack_state = S_RAH_ACK;
      S_RAL:   w_ack_state = S_RAL_ACK;
      S_WDATA: w_ack_state = S_WDATA_ACK;
      default: w_ack_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rdata_cap <= 8'h00;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_rd_d      <= 1'b0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_sda_oe    <= 1'b0;
    end else begin
      // Strobes are single-cycle by construction.
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_rd_d <= r_rd;

      // Local logic answers one clk after reg_rd; capture exactly then.
      if (r_rd_d) begin
        r_rdata_cap <= reg_rdata;
      end

      // Post-increment the pointer once the write strobe has been seen.
      if (r_wr) begin
        r_addr <= r_addr + 16'd1;
      end

      if (w_start) begin
        // Pointer is kept so a repeated START can follow a pointer write.
        r_state   <= S_DEV;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_DEV, S_RAH, S_RAL, S_WDATA: begin
            if (w_scl_rise && (r_bit_cnt != C_BYTE_DONE)) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == C_LAST_BIT) begin
                if (r_state == S_DEV) begin
                  if (w_byte[7:1] != DEV_ADDR) begin
                    r_state <= S_WAIT_STOP;
                  end else begin
                    r_busy <= 1'b1;
                    r_rw   <= w_byte[0];
                    r_rd   <= w_byte[0];
                  end
                end else if (r_state == S_RAH) begin
                  r_addr[15:8] <= w_byte;
                end else if (r_state == S_RAL) begin
                  r_addr[7:0] <= w_byte;
                end else begin
                  r_wdata <= w_byte;
                  r_wr    <= 1'b1;
                end
              end
            end else if (w_scl_fall && (r_bit_cnt == C_BYTE_DONE)) begin
              r_state  <= w_ack_state;
              r_sda_oe <= 1'b1;
            end
          end

          S_DEV_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_state  <= S_RDATA;
                r_shift  <= r_rdata_cap;
                r_sda_oe <= ~r_rdata_cap[7];
              end else begin
                r_state  <= S_RAH;
                r_sda_oe <= 1'b0;
              end
            end
          end

          S_RAH_ACK, S_RAL_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              r_sda_oe  <= 1'b0;
              r_state   <= (r_state == S_RAH_ACK) ? S_RAL : S_WDATA;
            end
          end

          S_RDATA: begin
            if (w_scl_rise && (r_bit_cnt != C_BYTE_DONE)) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == C_BYTE_DONE) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RDATA_ACK;
              end else if (r_bit_cnt == 4'd0) begin
                // First fall after a controller ACK: next byte goes out.
                r_shift  <= r_rdata_cap;
                r_sda_oe <= ~r_rdata_cap[7];
              end else begin
                // Rotate rather than shift; only the MSB is ever driven.
                r_shift  <= {r_shift[6:0], r_shift[7]};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end

          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (!r_sda_sync) begin
                r_addr    <= r_addr + 16'd1;
                r_rd      <= 1'b1;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RDATA;
              end else begin
                r_state <= S_WAIT_STOP;
              end
            end
          end

          default: begin
            // S_IDLE and S_WAIT_STOP ignore bits until the next bus condition.
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sdat  = r_sda_oe ? 1'b0 : 1'bz;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wr    = r_wr;
  assign reg_rd    = r_rd;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_reg_target
// Purpose  : Self-checking bench for i2c_reg_target. A bit-level I2C
//            controller drives the bus; a local-logic responder serves reads
//            from a device memory that also absorbs writes. Expected values
//            come from a transaction-level model (reference memory + pointer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_target;

  localparam int Q = 8;   // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;  // controller: 1 = release, 0 = drive low
  wire         sda;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_rdata;
  logic        busy;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_reg_target #(.DEV_ADDR(7'h48)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2c_sclk  (scl),
    .i2c_sdat  (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and device-side memory
  // --------------------------------------------------------------------------
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  dev_mem [0:65535];
  logic [7:0]  wbuf [0:7];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [15:0] rd_addr_q [$];
  int          overlap_cnt = 0, wide_wr = 0, wide_rd = 0, dut_drive = 0;

  // Bus monitor: logs strobes, tracks strobe shape, applies writes to dev_mem.
  initial begin
    logic prev_wr, prev_rd;
    prev_wr = 1'b0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_wr && reg_rd) overlap_cnt++;
      if (reg_wr && prev_wr) wide_wr++;
      if (reg_rd && prev_rd) wide_rd++;
      if (reg_wr) begin
        wr_addr_q.push_back(reg_addr);
        wr_data_q.push_back(reg_wdata);
        dev_mem[reg_addr] = reg_wdata;
      end
      if (reg_rd) rd_addr_q.push_back(reg_addr);
      if (sda === 1'b0 && m_sda) dut_drive++;
      prev_wr = reg_wr;
      prev_rd = reg_rd;
    end
  end

  // Local-logic responder: data is valid only in the clk after reg_rd.
  initial begin
    logic [15:0] a;
    reg_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (reg_rd) begin
        a = reg_addr;
        @(posedge clk);
        #1 reg_rdata = dev_mem[a];
        @(posedge clk);
        #1 reg_rdata = ~dev_mem[a];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bit-level controller
  // --------------------------------------------------------------------------
  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q_wait();
    scl   = 1'b1; q_wait();
    m_sda = 1'b0; q_wait();
    scl   = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q_wait();
    scl   = 1'b1; q_wait();
    m_sda = 1'b1; q_wait();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b;    q_wait();
    scl   = 1'b1; q_wait();
    s = sda;      q_wait();
    scl   = 1'b0; q_wait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(nack, s);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  // Pointer write + n data bytes; model: byte i lands at addr+i (16-bit wrap).
  task automatic do_write(input logic [15:0] addr, input int n);
    logic ack;
    int   bad;
    logic [15:0] a;
    bad = 0;
    clear_logs();
    i2c_start();
    send_byte(8'h90, ack); if (!ack) bad++;
    check("busy_after_match", 32'(busy), 32'd1);
    send_byte(addr[15:8], ack); if (!ack) bad++;
    send_byte(addr[7:0], ack);  if (!ack) bad++;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack); if (!ack) bad++;
    end
    i2c_stop();
    check("wr_acks_missing", 32'(bad), 32'd0);
    check("wr_count", 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      a = addr + 16'(i);
      check("wr_addr", 32'(wr_addr_q[i]), 32'(a));
      check("wr_data", 32'(wr_data_q[i]), 32'(wbuf[i]));
      ref_mem[a] = wbuf[i];
    end
    a = addr + 16'(n);
    check("ptr_after_write", 32'(reg_addr), 32'(a));
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  // Random read of n bytes; controller ACKs all but the last.
  task automatic do_read(input logic [15:0] addr, input int n);
    logic ack;
    int   bad;
    logic [7:0]  d;
    logic [15:0] a;
    bad = 0;
    clear_logs();
    i2c_start();
    send_byte(8'h90, ack); if (!ack) bad++;
    send_byte(addr[15:8], ack); if (!ack) bad++;
    send_byte(addr[7:0], ack);  if (!ack) bad++;
    i2c_start();
    send_byte(8'h91, ack); if (!ack) bad++;
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      a = addr + 16'(i);
      check("rd_data", 32'(d), 32'(ref_mem[a]));
    end
    check("rd_acks_missing", 32'(bad), 32'd0);
    a = addr + 16'(n - 1);
    check("ptr_after_nack", 32'(reg_addr), 32'(a));
    check("busy_wait_stop", 32'(busy), 32'd1);
    check("sda_released_wait_stop", 32'(sda), 32'd1);
    i2c_stop();
    check("busy_after_rd_stop", 32'(busy), 32'd0);
    check("rd_no_writes", 32'(wr_addr_q.size()), 32'd0);
    check("rd_strobe_count", 32'(rd_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
      a = addr + 16'(i);
      check("rd_strobe_addr", 32'(rd_addr_q[i]), 32'(a));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed + randomized sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0]  v;
    logic        ack, s;
    logic [15:0] raddr;
    int          n, drv0, waited;

    for (int a = 0; a < 65536; a++) begin
      v = 8'($urandom);
      ref_mem[a] = v;
      dev_mem[a] = v;
    end

    repeat (5) @(negedge clk);
    check("rst_reg_addr",  32'(reg_addr),  32'h0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
    check("rst_reg_wr",    32'(reg_wr),    32'h0);
    check("rst_reg_rd",    32'(reg_rd),    32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_sda",       32'(sda),       32'h1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write burst
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(16'h0010, 2);

    // Random read with known data
    ref_mem[16'h0020] = 8'h5A; dev_mem[16'h0020] = 8'h5A;
    ref_mem[16'h0021] = 8'hC3; dev_mem[16'h0021] = 8'hC3;
    do_read(16'h0020, 2);

    // Address mismatch: target must stay silent
    clear_logs();
    drv0 = dut_drive;
    raddr = reg_addr;
    i2c_start();
    send_byte(8'h92, ack);
    check("mismatch_no_ack", 32'(ack), 32'd0);
    check("mismatch_busy", 32'(busy), 32'd0);
    send_byte(8'h00, ack);
    send_byte(8'h10, ack);
    i2c_stop();
    check("mismatch_sda_driven", 32'(dut_drive - drv0), 32'd0);
    check("mismatch_strobes", 32'(wr_addr_q.size() + rd_addr_q.size()), 32'd0);
    check("mismatch_ptr", 32'(reg_addr), 32'(raddr));

    // Pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(16'hFFFF, 2);

    // Abort mid-byte: STOP after 4 data bits
    clear_logs();
    i2c_start();
    send_byte(8'h90, ack);
    send_byte(8'h00, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'b0, s);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("abort_no_wr", 32'(wr_addr_q.size()), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sda", 32'(sda), 32'd1);
    check("abort_ptr", 32'(reg_addr), 32'h0030);

    // Randomized write-then-readback against the reference model
    for (int k = 0; k < 4; k++) begin
      raddr = 16'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(raddr, n);
      do_read(raddr, n);
    end

    // Reset while the target holds the ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(v[0] ? 8'h90 >> i : 8'h90 >> i, s);
    m_sda = 1'b1;
    waited = 0;
    while (sda !== 1'b0 && waited < 4 * Q) begin
      @(negedge clk);
      waited++;
    end
    check("ack_driven_before_reset", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check("reset_sda_release", 32'(sda), 32'd1);
    @(negedge clk);
    check("reset_reg_addr",  32'(reg_addr),  32'h0);
    check("reset_reg_wdata", 32'(reg_wdata), 32'h0);
    check("reset_wr_rd",     32'({reg_wr, reg_rd}), 32'h0);
    check("reset_busy",      32'(busy),      32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    i2c_stop();

    // Recovery after reset
    wbuf[0] = 8'h77;
    do_write(16'h0040, 1);

    check("strobe_overlap", 32'(overlap_cnt), 32'd0);
    check("wr_strobe_width", 32'(wide_wr), 32'd0);
    check("rd_strobe_width", 32'(wide_rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
